// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among
// NREQ requesters, each presenting a fixed-length message of NBYTES words.
// The granted message is snapshotted, then sent word by word (LSB word first)
// over the transmitter's tx_start / tx_data / tx_done handshake.
//
// Optional feature macro: UART_ARB_ID_HEADER_EN
//   defined   -> a header word (HDR_BASE + requester index) precedes the payload
//   undefined -> exactly NBYTES words per message
//
// Ports:
//   clk_100MHz  in   system clock
//   reset       in   synchronous, active-high reset
//   req         in   [NREQ] level-sensitive request per requester
//   msg_data    in   [NREQ*DBITS*NBYTES] requester i message at i*MSG_W
//   ack         out  [NREQ] one-cycle pulse, message captured
//   done        out  [NREQ] one-cycle pulse, last word transmitted
//   busy        out  high whenever the controller is not idle
//   tx_start    out  one-cycle pulse per word to the transmitter
//   tx_data     out  [DBITS] word to the transmitter, held until next start
//   tx_done     in   transmitter end-of-word pulse
module uart_tx_arbiter #(
    parameter int unsigned DBITS    = 8,
    parameter int unsigned NBYTES   = 8,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned REQ_BITS = 2,
    parameter logic [7:0]  HDR_BASE = 8'h30
) (
    input  logic                            clk_100MHz,
    input  logic                            reset,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*DBITS*NBYTES-1:0]    msg_data,
    output logic [NREQ-1:0]                 ack,
    output logic [NREQ-1:0]                 done,
    output logic                            busy,
    output logic                            tx_start,
    output logic [DBITS-1:0]                tx_data,
    input  logic                            tx_done
);

    localparam int unsigned MSG_W = DBITS * NBYTES;
    localparam int unsigned CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [MSG_W-1:0]     msg_buf;
    logic [REQ_BITS-1:0]  idx;
    logic [REQ_BITS-1:0]  rr_last;
    logic [REQ_BITS-1:0]  pick;
    logic [REQ_BITS-1:0]  cand;
    logic                 pick_vld;
    logic [CNT_W-1:0]     byte_cnt, byte_cnt_nxt;

    logic [NREQ-1:0]      ack_nxt;
    logic [NREQ-1:0]      done_nxt;
    logic                 busy_nxt;
    logic                 tx_start_nxt;
    logic [DBITS-1:0]     tx_data_nxt;

`ifdef UART_ARB_ID_HEADER_EN
    logic                 hdr_pend, hdr_pend_nxt;
`endif

    // Round-robin pick: first asserted request after rr_last, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = REQ_BITS'((32'(rr_last) + k) % NREQ);
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state    <= S_IDLE;
            byte_cnt <= '0;
            rr_last  <= REQ_BITS'(NREQ - 1);
            idx      <= '0;
            msg_buf  <= '0;
            ack      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
`ifdef UART_ARB_ID_HEADER_EN
            hdr_pend <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            ack      <= ack_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
`ifdef UART_ARB_ID_HEADER_EN
            hdr_pend <= hdr_pend_nxt;
`endif
            // Snapshot: later changes to req/msg_data cannot disturb the transfer.
            if (state == S_IDLE && pick_vld) begin
                idx     <= pick;
                msg_buf <= msg_data[32'(pick) * MSG_W +: MSG_W];
            end
            if (state == S_DONE) begin
                rr_last <= idx;
            end
        end
    end

    // Next-state and word counter.
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
`ifdef UART_ARB_ID_HEADER_EN
        hdr_pend_nxt = hdr_pend;
`endif
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                byte_cnt_nxt = '0;
`ifdef UART_ARB_ID_HEADER_EN
                hdr_pend_nxt = 1'b1;
`endif
                state_nxt    = S_START;
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // tx_done is only honoured here; elsewhere it is ignored.
                if (tx_done) begin
`ifdef UART_ARB_ID_HEADER_EN
                    if (hdr_pend) begin
                        hdr_pend_nxt = 1'b0;
                        state_nxt    = S_START;
                    end else
`endif
                    if (byte_cnt == CNT_W'(NBYTES - 1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        byte_cnt_nxt = byte_cnt + CNT_W'(1);
                        state_nxt    = S_START;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered-output next values, keyed on the state being entered.
    always_comb begin
        ack_nxt      = '0;
        done_nxt     = '0;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        busy_nxt     = (state_nxt != S_IDLE);

        if (state_nxt == S_GRANT) begin
            ack_nxt[pick] = 1'b1;
        end
        if (state_nxt == S_DONE) begin
            done_nxt[idx] = 1'b1;
        end
        if (state_nxt == S_START) begin
            tx_start_nxt = 1'b1;
`ifdef UART_ARB_ID_HEADER_EN
            if (hdr_pend_nxt) begin
                tx_data_nxt = DBITS'(32'(HDR_BASE) + 32'(idx));
            end else begin
                tx_data_nxt = msg_buf[32'(byte_cnt_nxt) * DBITS +: DBITS];
            end
`else
            tx_data_nxt = msg_buf[32'(byte_cnt_nxt) * DBITS +: DBITS];
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the bench plays the transmitter,
// answering each tx_start with a tx_done after a chosen delay.
module tb_uart_tx_arbiter;

    localparam int unsigned DBITS    = 8;
    localparam int unsigned NBYTES   = 8;
    localparam int unsigned NREQ     = 4;
    localparam int unsigned REQ_BITS = 2;
`ifdef UART_ARB_ID_HEADER_EN
    localparam int NWORDS = NBYTES + 1;
`else
    localparam int NWORDS = NBYTES;
`endif

    logic                          clk_100MHz = 1'b0;
    logic                          reset;
    logic [NREQ-1:0]               req;
    logic [NREQ*DBITS*NBYTES-1:0]  msg_data;
    logic [NREQ-1:0]               ack;
    logic [NREQ-1:0]               done;
    logic                          busy;
    logic                          tx_start;
    logic [DBITS-1:0]              tx_data;
    logic                          tx_done;

    int vectors     = 0;
    int miscompares = 0;

    // Results gathered by serve_msg.
    logic [7:0]      words [0:15];
    logic [NREQ-1:0] ack_seen, done_seen;
    int              nstarts, ack_cyc, done_lat;
    logic            busy_after;
    bit              timed_out;

    uart_tx_arbiter #(
        .DBITS   (DBITS),
        .NBYTES  (NBYTES),
        .NREQ    (NREQ),
        .REQ_BITS(REQ_BITS),
        .HDR_BASE(8'h30)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .req       (req),
        .msg_data  (msg_data),
        .ack       (ack),
        .done      (done),
        .busy      (busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Expected word j of requester r's transmission.
    function automatic logic [7:0] exp_word(input int r, input int j);
`ifdef UART_ARB_ID_HEADER_EN
        if (j == 0) return 8'(32'h30 + r);
        return 8'(32'h41 + 16 * r + j - 1);
`else
        return 8'(32'h41 + 16 * r + j);
`endif
    endfunction

    task automatic set_msgs();
        for (int r = 0; r < NREQ; r++)
            for (int b = 0; b < NBYTES; b++)
                msg_data[r*64 + b*8 +: 8] = 8'(32'h41 + 16 * r + b);
    endtask

    task automatic do_reset();
        @(negedge clk_100MHz);
        reset   = 1'b1;
        req     = '0;
        tx_done = 1'b0;
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        reset = 1'b0;
    endtask

    // Transmitter model; call at a negedge right after driving req.
    task automatic serve_msg(input int dly, input bit drop_req, input bit scramble);
        int cd;
        int last_done;
        cd = 0; last_done = -100;
        nstarts = 0; ack_seen = '0; done_seen = '0;
        ack_cyc = -1; done_lat = -1; busy_after = 1'bx; timed_out = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk_100MHz);
            tx_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    tx_done   = 1'b1;
                    last_done = cyc;
                end
            end
            if (ack != '0) begin
                ack_seen = ack;
                ack_cyc  = cyc;
                if (drop_req) req = '0;
                if (scramble) msg_data = {4{64'hDEADBEEFCAFEF00D}};
            end
            if (tx_start) begin
                if (nstarts < 16) words[nstarts] = tx_data;
                nstarts++;
                cd = dly + 1;
            end
            if (done != '0) begin
                done_seen = done;
                done_lat  = cyc - last_done;
                @(negedge clk_100MHz);
                busy_after = busy;
                return;
            end
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({ack, done, busy, tx_start, tx_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ack=%b done=%b busy=%b tx_start=%b tx_data=%h, want all zero",
                     ack, done, busy, tx_start, tx_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_msgs();
        req = 4'b0001;
        serve_msg(2, 1'b1, 1'b0);
        vectors++;
        if (timed_out !== 1'b0) begin miscompares++; $display("FAIL single_timeout: got timeout, want done"); end
        vectors++;
        if (ack_seen !== 4'b0001 || ack_cyc !== 0) begin
            miscompares++;
            $display("FAIL single_ack: got %b at cycle %0d, want 0001 at cycle 0", ack_seen, ack_cyc);
        end
        vectors++;
        if (nstarts !== NWORDS) begin
            miscompares++; $display("FAIL single_nstarts: got %0d want %0d", nstarts, NWORDS);
        end
        for (int j = 0; j < NWORDS; j++) begin
            vectors++;
            if (words[j] !== exp_word(0, j)) begin
                miscompares++; $display("FAIL single_word%0d: got %h want %h", j, words[j], exp_word(0, j));
            end
        end
        vectors++;
        if (done_seen !== 4'b0001 || done_lat !== 1) begin
            miscompares++;
            $display("FAIL single_done: got %b latency %0d, want 0001 latency 1", done_seen, done_lat);
        end
        vectors++;
        if (busy_after !== 1'b0) begin
            miscompares++; $display("FAIL single_busy_after: got %b want 0", busy_after);
        end
    endtask

    task automatic test_round_robin();
        int order [8] = '{0, 1, 2, 3, 0, 2, 0, 2};
        logic [NREQ-1:0] expv;
        do_reset();
        set_msgs();
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            serve_msg(0, 1'b0, 1'b0);
            if (n == 4) req = 4'b0101;
            if (n == 7) req = 4'b0000;
            expv = 4'b0001 << order[n];
            vectors++;
            if (ack_seen !== expv || done_seen !== expv) begin
                miscompares++;
                $display("FAIL rr_grant%0d: ack=%b done=%b want %b", n, ack_seen, done_seen, expv);
            end
            vectors++;
            if (words[0] !== exp_word(order[n], 0) || nstarts !== NWORDS) begin
                miscompares++;
                $display("FAIL rr_data%0d: first=%h starts=%0d want %h starts=%0d",
                         n, words[0], nstarts, exp_word(order[n], 0), NWORDS);
            end
        end
        @(negedge clk_100MHz);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_snapshot();
        int bad;
        do_reset();
        set_msgs();
        req = 4'b0010;
        serve_msg(1, 1'b1, 1'b1);
        bad = 0;
        for (int j = 0; j < NWORDS; j++) if (words[j] !== exp_word(1, j)) bad++;
        vectors++;
        if (bad != 0 || nstarts !== NWORDS) begin
            miscompares++;
            $display("FAIL snapshot_words: %0d wrong words, starts=%0d, want 0 wrong, starts=%0d", bad, nstarts, NWORDS);
        end
        vectors++;
        if (ack_seen !== 4'b0010 || done_seen !== 4'b0010) begin
            miscompares++;
            $display("FAIL snapshot_handshake: ack=%b done=%b want 0010/0010", ack_seen, done_seen);
        end
        set_msgs();
    endtask

    task automatic test_reset_mid();
        int  st;
        bit  pend;
        bit  hit;
        int  stray;
        do_reset();
        set_msgs();
        req = 4'b0001;
        st = 0; pend = 1'b0; hit = 1'b0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            @(negedge clk_100MHz);
            tx_done = 1'b0;
            if (ack != '0) req = '0;
            if (pend) begin tx_done = 1'b1; pend = 1'b0; end
            if (tx_start) begin
                st++;
                if (st == NWORDS - NBYTES + 4) hit = 1'b1;
                else pend = 1'b1;
            end
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL midreset_reach: got %0d starts want %0d", st, NWORDS - NBYTES + 4); end
        @(negedge clk_100MHz);
        reset = 1'b1;
        @(negedge clk_100MHz);
        vectors++;
        if ({busy, tx_start, done, ack, tx_data} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: busy=%b tx_start=%b done=%b ack=%b tx_data=%h want all zero",
                     busy, tx_start, done, ack, tx_data);
        end
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_100MHz);
            if (done != '0 || busy) stray++;
        end
        vectors++;
        if (stray != 0) begin miscompares++; $display("FAIL midreset_quiet: got %0d active cycles want 0", stray); end
        req = 4'b0100;
        serve_msg(0, 1'b1, 1'b0);
        vectors++;
        if (ack_seen !== 4'b0100 || done_seen !== 4'b0100) begin
            miscompares++; $display("FAIL midreset_next: ack=%b done=%b want 0100/0100", ack_seen, done_seen);
        end
        vectors++;
        if (words[0] !== exp_word(2, 0) || nstarts !== NWORDS) begin
            miscompares++;
            $display("FAIL midreset_from_byte0: first=%h starts=%0d want %h starts=%0d",
                     words[0], nstarts, exp_word(2, 0), NWORDS);
        end
    endtask

    task automatic test_spurious_done();
        int bad;
        do_reset();
        set_msgs();
        tx_done = 1'b1;
        @(negedge clk_100MHz);
        vectors++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            miscompares++; $display("FAIL spur_idle: busy=%b tx_start=%b want 0/0", busy, tx_start);
        end
        req = 4'b0001;
        @(negedge clk_100MHz);
        vectors++;
        if (ack !== 4'b0001 || tx_start !== 1'b0) begin
            miscompares++; $display("FAIL spur_grant: ack=%b tx_start=%b want 0001/0", ack, tx_start);
        end
        req = '0;
        @(negedge clk_100MHz);
        vectors++;
        if (tx_start !== 1'b1 || tx_data !== exp_word(0, 0)) begin
            miscompares++;
            $display("FAIL spur_start: tx_start=%b tx_data=%h want 1/%h", tx_start, tx_data, exp_word(0, 0));
        end
        @(negedge clk_100MHz);
        tx_done = 1'b0;
        vectors++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL spur_wait: tx_start=%b busy=%b want 0/1", tx_start, busy);
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_100MHz);
            if (tx_start || tx_data !== exp_word(0, 0) || done != '0 || !busy) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL spur_long_hold: got %0d bad cycles want 0", bad); end
        tx_done = 1'b1;
        serve_msg(0, 1'b0, 1'b0);
        vectors++;
        if (nstarts !== NWORDS - 1 || words[0] !== exp_word(0, 1) || done_seen !== 4'b0001) begin
            miscompares++;
            $display("FAIL spur_finish: starts=%0d first=%h done=%b want %0d/%h/0001",
                     nstarts, words[0], done_seen, NWORDS - 1, exp_word(0, 1));
        end
    endtask

`ifdef UART_ARB_ID_HEADER_EN
    task automatic test_header();
        do_reset();
        set_msgs();
        req = 4'b0010;
        serve_msg(1, 1'b1, 1'b0);
        vectors++;
        if (words[0] !== 8'h31 || nstarts !== 9) begin
            miscompares++; $display("FAIL header_word: first=%h starts=%0d want 31/9", words[0], nstarts);
        end
        vectors++;
        if (words[1] !== 8'h51 || words[8] !== 8'h58) begin
            miscompares++; $display("FAIL header_payload: w1=%h w8=%h want 51/58", words[1], words[8]);
        end
        vectors++;
        if (done_seen !== 4'b0010 || done_lat !== 1) begin
            miscompares++; $display("FAIL header_done: got %b latency %0d want 0010 latency 1", done_seen, done_lat);
        end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        req      = '0;
        tx_done  = 1'b0;
        msg_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_snapshot();
        test_reset_mid();
        test_spurious_done();
`ifdef UART_ARB_ID_HEADER_EN
        test_header();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
